// File: rtl/da_pkg.sv
// Shared types and elaboration-time helpers for the distributed-arithmetic MAC engine.
//   state_e   : engine sequencing states
//   acc_width : exact accumulator width for a given coefficient/sample/tap sizing
//   rom_fill  : partial-sum ROM entry (sum of a row's coefficients selected by addr bits)
package da_pkg;

  // Upper bound on the packed coefficient vector handed to rom_fill.
  localparam int unsigned COEFS_MAX_W = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned acc_width(input int unsigned coef_w,
                                            input int unsigned data_w,
                                            input int unsigned taps);
    return coef_w + data_w + $clog2(taps);
  endfunction

  // Sum of coef[row][k] over every set bit k of addr, each coefficient sign-extended.
  function automatic logic signed [63:0] rom_fill(input int unsigned row,
                                                  input int unsigned addr,
                                                  input int unsigned taps,
                                                  input int unsigned coef_w,
                                                  input logic [COEFS_MAX_W-1:0] coefs);
    logic signed [63:0] sum;
    logic signed [63:0] c;
    sum = '0;
    for (int unsigned k = 0; k < taps; k++) begin
      if (addr[k]) begin
        c = '0;
        for (int unsigned b = 0; b < coef_w; b++) begin
          c[b] = coefs[(row * taps + k) * coef_w + b];
        end
        if (c[coef_w-1]) begin
          for (int unsigned b = coef_w; b < 64; b++) begin
            c[b] = 1'b1;
          end
        end
        sum = sum + c;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/da_rom.sv
// Partial-sum ROM for the DA engine: one table of 2**TAPS entries per coefficient row,
// filled at elaboration. Purely combinational lookup.
//   row    : coefficient row select (rows >= NUM_SETS alias row 0)
//   addr   : one bit per tap (current sample bit of each tap)
//   data_c : sign-extended sum of the selected row's coefficients
module da_rom
  import da_pkg::*;
#(
  parameter int unsigned TAPS     = 4,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned NUM_SETS = 8,
  parameter logic [NUM_SETS*TAPS*COEF_W-1:0] COEFS = {(NUM_SETS*TAPS){16'h2D41}},
  localparam int unsigned ROW_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int unsigned ENT_W = COEF_W + $clog2(TAPS)
) (
  input  logic [ROW_W-1:0]        row,
  input  logic [TAPS-1:0]         addr,
  output logic signed [ENT_W-1:0] data_c
);

  localparam int unsigned NUM_ROWS = 2 ** ROW_W;
  localparam int unsigned NUM_ADDR = 2 ** TAPS;

  logic signed [ENT_W-1:0] rom_tbl [NUM_ROWS][NUM_ADDR];

  // Unused row codes are filled with row 0 so out-of-range selects need no extra mux.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    localparam int unsigned SRC_ROW = (r < NUM_SETS) ? r : 0;
    for (genvar a = 0; a < NUM_ADDR; a++) begin : g_addr
      assign rom_tbl[r][a] = ENT_W'(rom_fill(SRC_ROW, a, TAPS, COEF_W, COEFS_MAX_W'(COEFS)));
    end
  end

  assign data_c = rom_tbl[row][addr];

endmodule

// File: rtl/da_mac_engine.sv
// Bit-serial distributed-arithmetic dot product: out = sum_k coef[row][k] * x[k],
// processed MSB first, one sample bit per cycle, with valid/ready handshakes.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : sample vector + row_sel handshake
//   in_data, row_sel     : TAPS signed samples (tap k at [k*DATA_W +: DATA_W]), coefficient row
//   out_valid/out_ready  : result handshake, out_data held until accepted
//   out_data             : exact signed result, coefficient fractional scaling retained
//   busy                 : engine not idle
module da_mac_engine
  import da_pkg::*;
#(
  parameter int unsigned TAPS     = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned FRAC_W   = 14,
  parameter int unsigned NUM_SETS = 8,
  parameter logic [NUM_SETS*TAPS*COEF_W-1:0] COEFS = {(NUM_SETS*TAPS){16'h2D41}},
  localparam int unsigned ACC_W = acc_width(COEF_W, DATA_W, TAPS),
  localparam int unsigned ROW_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*DATA_W-1:0] in_data,
  input  logic [ROW_W-1:0]       row_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   busy
);

  localparam int unsigned J_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned ENT_W = COEF_W + $clog2(TAPS);

  // Coefficients must keep at least one integer (sign) bit.
  if (FRAC_W >= COEF_W) begin : g_frac_chk
    $error("da_mac_engine: FRAC_W must be smaller than COEF_W");
  end

  state_e                   state_q, state_d;
  logic [TAPS*DATA_W-1:0]   x_q, x_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [J_W-1:0]           j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;

  logic [TAPS-1:0]          rom_addr_c;
  logic signed [ENT_W-1:0]  rom_data_c;
  logic signed [ACC_W-1:0]  rom_ext_c;

  // Samples shift left each CALC cycle, so the current bit is always each sample's MSB.
  always_comb begin
    rom_addr_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      rom_addr_c[k] = x_q[k*DATA_W + DATA_W - 1];
    end
  end

  da_rom #(
    .TAPS     (TAPS),
    .COEF_W   (COEF_W),
    .NUM_SETS (NUM_SETS),
    .COEFS    (COEFS)
  ) u_rom (
    .row    (row_q),
    .addr   (rom_addr_c),
    .data_c (rom_data_c)
  );

  assign rom_ext_c = ACC_W'(rom_data_c);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    row_d   = row_q;
    j_d     = j_q;
    acc_d   = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          x_d     = in_data;
          row_d   = row_sel;
          j_d     = J_W'(DATA_W - 1);
          acc_d   = '0;
        end
      end
      ST_CALC: begin
        // Sign bit carries weight -2^(DATA_W-1), hence the subtraction.
        if (j_q == J_W'(DATA_W - 1)) begin
          acc_d = (acc_q <<< 1) - rom_ext_c;
        end else begin
          acc_d = (acc_q <<< 1) + rom_ext_c;
        end
        for (int k = 0; k < TAPS; k++) begin
          x_d[k*DATA_W +: DATA_W] = x_q[k*DATA_W +: DATA_W] << 1;
        end
        j_d = j_q - J_W'(1);
        if (j_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      row_q       <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      row_q       <= row_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_da_mac_engine.sv
// Self-checking bench for da_mac_engine: arithmetic/timing reference model plus
// directed vectors with literal expected results.
module tb_da_mac_engine;

  localparam int unsigned TAPS     = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned NUM_SETS = 8;
  localparam int unsigned ACC_W    = 34;

  // Row 0 = {2D41, D2BF, D2BF, 2D41} (tap 0 first), row 1 = all 4000, others 2D41.
  localparam logic [NUM_SETS*TAPS*COEF_W-1:0] COEFS =
    {{6{64'h2D41_2D41_2D41_2D41}}, 64'h4000_4000_4000_4000, 64'h2D41_D2BF_D2BF_2D41};

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [TAPS*DATA_W-1:0] in_data = '0;
  logic [2:0]             row_sel = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [ACC_W-1:0]       out_data;
  logic                   busy;

  always #5 clk = ~clk;

  da_mac_engine #(
    .TAPS     (TAPS),
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .FRAC_W   (14),
    .NUM_SETS (NUM_SETS),
    .COEFS    (COEFS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .row_sel   (row_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  int     n_checks = 0;
  int     n_err    = 0;
  bit     chk_en   = 1'b0;
  int     cyc      = 0;
  int     coef_m [NUM_SETS][TAPS];

  // Reference model: 0 = idle, 1 = computing, 2 = result waiting.
  int     m_state = 0;
  int     m_cnt   = 0;
  longint m_res   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint dot(input logic [TAPS*DATA_W-1:0] d, input logic [2:0] r);
    longint s;
    logic signed [DATA_W-1:0] v;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      v = d[k*DATA_W +: DATA_W];
      s = s + longint'(coef_m[r][k]) * longint'(v);
    end
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_state <= 1;
          m_cnt   <= DATA_W;
          m_res   <= dot(in_data, row_sel);
        end
        1: if (m_cnt == 1) m_state <= 2; else m_cnt <= m_cnt - 1;
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", longint'(in_ready), longint'(m_state == 0));
      chk("out_valid", longint'(out_valid), longint'(m_state == 2));
      chk("busy", longint'(busy), longint'(m_state != 0));
      if (m_state == 2) chk("out_data", longint'($signed(out_data)), m_res);
    end
  end

  task automatic drive(input int x0, input int x1, input int x2, input int x3, input int r);
    in_valid = 1'b1;
    in_data  = {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    row_sel  = 3'(r);
  endtask

  task automatic wait_result(input string name, input longint exp, output int t);
    bit found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk(name, longint'($signed(out_data)), exp);
        t = cyc;
        found = 1'b1;
      end
    end
    if (!found) chk("timeout", 0, 1);
  endtask

  // One complete operation with out_ready held high; returns cycles busy was high.
  task automatic run_op(input string name, input int x0, input int x1, input int x2,
                        input int x3, input int r, input longint exp, output int busy_cyc);
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    busy_cyc = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(x0, x1, x2, x3, r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        chk(name, longint'($signed(out_data)), exp);
        seen = 1'b1;
      end
      if (busy) busy_cyc++; else done = 1'b1;
    end
    if (!seen || !done) chk("timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int t1;
    int t2;
    for (int r = 0; r < NUM_SETS; r++)
      for (int k = 0; k < TAPS; k++) coef_m[r][k] = 11585;
    coef_m[0][1] = -11585;
    coef_m[0][2] = -11585;
    for (int k = 0; k < TAPS; k++) coef_m[1][k] = 16384;

    // Pin the model to hand-computed values.
    chk("model_row0_unit", dot({16'd0, 16'd0, 16'd0, 16'd1}, 3'd0), 11585);
    chk("model_row0_ext", dot({16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000}, 3'd0), -1518445950);
    chk("model_row1", dot({16'd4, 16'd3, 16'd2, 16'd1}, 3'd1), 163840);

    // Reset values.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_busy", longint'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("unit_pos", 1, 0, 0, 0, 0, 11585, bc);
    chk("busy_cycles", bc, 17);
    run_op("unit_neg", -1, 0, 0, 0, 0, -11585, bc);
    run_op("extreme", -32768, 32767, 32767, -32768, 0, -1518445950, bc);
    run_op("row2_mixed", 100, -200, 300, -400, 2, -2317000, bc);

    // Back-to-back: row 1 then row 0, in_valid held high throughout.
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1, 2, 3, 4, 1);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0);
    wait_result("b2b_row1", 163840, t1);
    @(posedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("b2b_row0", 11585, t2);
    chk("throughput", t2 - t1, DATA_W + 2);

    // Output stall with in_valid toggling.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(-1, 0, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("stall_first", -11585, t1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      @(negedge clk);
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_data", longint'($signed(out_data)), -11585);
      chk("stall_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 1);
    chk("release_out_valid", longint'(out_valid), 0);

    // Reset during the CALC cycle that handles bit 8.
    @(posedge clk); #1;
    drive(3, 0, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    run_op("after_rst", -32768, 32767, 32767, -32768, 0, -1518445950, bc);
    chk("after_rst_busy", bc, 17);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
